// File: rtl/csc_row_sched.sv
// Row sequencer for the CSC row-vector generator: takes one matrix configuration,
// issues MAT_RANK/2 shifted row requests one at a time and forwards each result tagged.
module csc_row_sched #(
    parameter int MAT_RANK = 256
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         cfg_vld,
    output logic                         cfg_rdy,
    input  logic [31:0]                  cfg_z0,
    input  logic [31:0]                  cfg_z1,
    input  logic [31:0]                  cfg_s_i,
    input  logic [31:0]                  cfg_s_r,
    input  logic [31:0]                  cfg_a0_i,
    input  logic [31:0]                  cfg_a0_r,
    input  logic [31:0]                  cfg_a1_i,
    input  logic [31:0]                  cfg_a1_r,
    input  logic                         abort,

    output logic [31:0]                  z0_o,
    output logic [31:0]                  z1_o,
    output logic [31:0]                  s_val_i_o,
    output logic [31:0]                  s_val_r_o,
    output logic [31:0]                  a0_val_i_o,
    output logic [31:0]                  a0_val_r_o,
    output logic [31:0]                  a1_val_i_o,
    output logic [31:0]                  a1_val_r_o,
    output logic                         val_vld_o,
    input  logic                         val_rdy_i,
    input  logic                         gen_vld_i,
    output logic                         gen_rdy_o,

    output logic                         row_vld,
    input  logic                         row_rdy,
    output logic [$clog2(MAT_RANK)-2:0]  row_idx,
    output logic                         row_last,
    output logic                         busy,
    output logic                         done
);

    localparam int INDEX_W = $clog2(MAT_RANK);
    localparam int ROW_W   = INDEX_W - 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAT_RANK / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] r;
    logic [ROW_W-1:0] r_next;
    logic [ROW_W-1:0] idx0;
    logic [ROW_W-1:0] idx1;
    logic             abort_flag;
    logic             gen_xfer;
    logic             cfg_unused;

    // Position field lives at bit 16; the add wraps naturally modulo MAT_RANK/2.
    function automatic logic [31:0] pack_pos(input logic [ROW_W-1:0] base,
                                             input logic [ROW_W-1:0] ofs);
        logic [ROW_W-1:0] pos;
        pos = base + ofs;
        return 32'(pos) << 16;
    endfunction

    assign r_next     = r + ROW_W'(1);
    assign row_idx    = r;
    assign cfg_unused = ^{cfg_z0, cfg_z1};

    // While aborting, results are swallowed here and never reach the consumer.
    assign row_vld  = (state == S_WAIT) && gen_vld_i && !abort_flag;
    assign gen_rdy_o = (state == S_WAIT) && (abort_flag || row_rdy);
    assign gen_xfer = gen_vld_i && gen_rdy_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            r          <= '0;
            idx0       <= '0;
            idx1       <= '0;
            abort_flag <= 1'b0;
            cfg_rdy    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            val_vld_o  <= 1'b0;
            row_last   <= 1'b0;
            z0_o       <= '0;
            z1_o       <= '0;
            s_val_i_o  <= '0;
            s_val_r_o  <= '0;
            a0_val_i_o <= '0;
            a0_val_r_o <= '0;
            a1_val_i_o <= '0;
            a1_val_r_o <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_vld) begin
                        idx0       <= cfg_z0[16 +: ROW_W];
                        idx1       <= cfg_z1[16 +: ROW_W];
                        z0_o       <= pack_pos(cfg_z0[16 +: ROW_W], '0);
                        z1_o       <= pack_pos(cfg_z1[16 +: ROW_W], '0);
                        s_val_i_o  <= cfg_s_i;
                        s_val_r_o  <= cfg_s_r;
                        a0_val_i_o <= cfg_a0_i;
                        a0_val_r_o <= cfg_a0_r;
                        a1_val_i_o <= cfg_a1_i;
                        a1_val_r_o <= cfg_a1_r;
                        r          <= '0;
                        row_last   <= 1'b0;
                        abort_flag <= 1'b0;
                        cfg_rdy    <= 1'b0;
                        busy       <= 1'b1;
                        val_vld_o  <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // A handshake on the abort cycle still leaves a result to drain.
                    if (val_rdy_i) begin
                        val_vld_o  <= 1'b0;
                        abort_flag <= abort;
                        state      <= S_WAIT;
                    end else if (abort) begin
                        val_vld_o <= 1'b0;
                        cfg_rdy   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                S_WAIT: begin
                    if (gen_xfer) begin
                        if (abort_flag || abort) begin
                            abort_flag <= 1'b0;
                            cfg_rdy    <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else if (r == LAST_ROW) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            r         <= r_next;
                            row_last  <= (r_next == LAST_ROW);
                            z0_o      <= pack_pos(idx0, r_next);
                            z1_o      <= pack_pos(idx1, r_next);
                            val_vld_o <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end else if (abort) begin
                        abort_flag <= 1'b1;
                    end
                end

                S_DONE: begin
                    cfg_rdy <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    val_vld_o  <= 1'b0;
                    abort_flag <= 1'b0;
                    cfg_rdy    <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csc_row_sched.sv
// Directed bench for csc_row_sched at MAT_RANK=8 with a behavioural generator model.
module tb_csc_row_sched;

    localparam int MAT_RANK = 8;
    localparam int IW = $clog2(MAT_RANK);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_vld = 1'b0;
    logic        cfg_rdy;
    logic [31:0] cfg_z0 = '0, cfg_z1 = '0;
    logic [31:0] cfg_s_i = '0, cfg_s_r = '0, cfg_a0_i = '0, cfg_a0_r = '0, cfg_a1_i = '0, cfg_a1_r = '0;
    logic        abort = 1'b0;
    logic [31:0] z0_o, z1_o;
    logic [31:0] s_val_i_o, s_val_r_o, a0_val_i_o, a0_val_r_o, a1_val_i_o, a1_val_r_o;
    logic        val_vld_o;
    logic        val_rdy = 1'b1;
    logic        gen_vld;
    logic        gen_rdy_o;
    logic        row_vld;
    logic        row_rdy = 1'b1;
    logic [IW-2:0] row_idx;
    logic        row_last;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail = 0;

    // generator model state and logs
    int          gen_lat = 0;
    logic        gen_pend;
    int          gen_cnt;
    logic [31:0] iss_z0 [0:63];
    logic [31:0] iss_z1 [0:63];
    int          n_iss = 0;
    logic [IW-2:0] rl_idx [0:63];
    logic        rl_last [0:63];
    int          n_rows = 0;
    int          n_done = 0;
    int          n_both = 0;

    always #5 clk = ~clk;

    csc_row_sched #(.MAT_RANK(MAT_RANK)) dut (
        .clk(clk), .rst(rst),
        .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
        .cfg_z0(cfg_z0), .cfg_z1(cfg_z1),
        .cfg_s_i(cfg_s_i), .cfg_s_r(cfg_s_r),
        .cfg_a0_i(cfg_a0_i), .cfg_a0_r(cfg_a0_r),
        .cfg_a1_i(cfg_a1_i), .cfg_a1_r(cfg_a1_r),
        .abort(abort),
        .z0_o(z0_o), .z1_o(z1_o),
        .s_val_i_o(s_val_i_o), .s_val_r_o(s_val_r_o),
        .a0_val_i_o(a0_val_i_o), .a0_val_r_o(a0_val_r_o),
        .a1_val_i_o(a1_val_i_o), .a1_val_r_o(a1_val_r_o),
        .val_vld_o(val_vld_o), .val_rdy_i(val_rdy),
        .gen_vld_i(gen_vld), .gen_rdy_o(gen_rdy_o),
        .row_vld(row_vld), .row_rdy(row_rdy),
        .row_idx(row_idx), .row_last(row_last),
        .busy(busy), .done(done)
    );

    // Generator: result appears gen_lat cycles after the cycle following the request handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_vld  <= 1'b0;
            gen_pend <= 1'b0;
            gen_cnt  <= 0;
        end else begin
            if (gen_vld && gen_rdy_o) gen_vld <= 1'b0;
            if (val_vld_o && val_rdy) begin
                if (n_iss < 64) begin
                    iss_z0[n_iss] <= z0_o;
                    iss_z1[n_iss] <= z1_o;
                end
                n_iss <= n_iss + 1;
                if (gen_lat == 0) gen_vld <= 1'b1;
                else begin
                    gen_pend <= 1'b1;
                    gen_cnt  <= gen_lat;
                end
            end else if (gen_pend) begin
                if (gen_cnt == 1) begin
                    gen_vld  <= 1'b1;
                    gen_pend <= 1'b0;
                end
                gen_cnt <= gen_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (row_vld && row_rdy) begin
            if (n_rows < 64) begin
                rl_idx[n_rows]  <= row_idx;
                rl_last[n_rows] <= row_last;
            end
            n_rows <= n_rows + 1;
        end
        if (done) n_done <= n_done + 1;
        if (val_vld_o && gen_rdy_o) n_both <= n_both + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] zpos(input int p);
        return 32'(p) << 16;
    endfunction

    // Junk outside bits [17:16] must be ignored by the DUT.
    task automatic start(input int i0, input int i1);
        cfg_z0   = 32'hDEAC_BEEF | zpos(i0);
        cfg_z1   = 32'h5A5C_A5A5 | zpos(i1);
        cfg_s_i  = 32'h1111_0001;
        cfg_s_r  = 32'h2222_0002;
        cfg_a0_i = 32'h3333_0003;
        cfg_a0_r = 32'h4444_0004;
        cfg_a1_i = 32'h5555_0005;
        cfg_a1_r = 32'h6666_0006;
        cfg_vld  = 1'b1;
        step();
        cfg_vld  = 1'b0;
    endtask

    task automatic run_to_idle(input string tag, input int max);
        for (int k = 0; k < max && busy; k++) step();
        chk(tag, busy, 1'b0);
    endtask

    task automatic check_run(input string tag, input int bi, input int br, input int bd,
                             input int e0[4], input int e1[4]);
        chk({tag, "_nreq"}, n_iss - bi, 4);
        chk({tag, "_nrows"}, n_rows - br, 4);
        chk({tag, "_ndone"}, n_done - bd, 1);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_z0"}, iss_z0[bi + i], zpos(e0[i]));
            chk({tag, "_z1"}, iss_z1[bi + i], zpos(e1[i]));
            chk({tag, "_ridx"}, rl_idx[br + i], i);
            chk({tag, "_rlast"}, rl_last[br + i], (i == 3));
        end
    endtask

    initial begin
        int bi, br, bd, k, seen;
        int ea[4];
        int eb[4];

        // reset state
        #12;
        chk("rst_cfg_rdy", cfg_rdy, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_val_vld", val_vld_o, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_z0", z0_o, 32'h0);
        chk("rst_row_last", row_last, 1'b0);
        step();
        rst = 1'b0;
        step();

        // nominal run idx0=1 idx1=3
        bi = n_iss; br = n_rows; bd = n_done;
        start(1, 3);
        chk("t1_busy", busy, 1'b1);
        chk("t1_cfg_rdy", cfg_rdy, 1'b0);
        chk("t1_val_vld", val_vld_o, 1'b1);
        chk("t1_z0_first", z0_o, 32'h0001_0000);
        chk("t1_z1_first", z1_o, 32'h0003_0000);
        chk("t1_s_i", s_val_i_o, 32'h1111_0001);
        chk("t1_a0_r", a0_val_r_o, 32'h4444_0004);
        chk("t1_a1_r", a1_val_r_o, 32'h6666_0006);
        for (k = 1; k <= 40; k++) begin
            step();
            if (done) break;
        end
        chk("t1_done_cycle", k, 8);
        chk("t1_done_seen", done, 1'b1);
        step();
        chk("t1_busy_drop", busy, 1'b0);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_cfg_rdy_back", cfg_rdy, 1'b1);
        ea = '{1, 2, 3, 0};
        eb = '{3, 0, 1, 2};
        check_run("t1", bi, br, bd, ea, eb);

        // back-pressure on row 1
        bi = n_iss; br = n_rows; bd = n_done;
        start(0, 0);
        for (k = 0; k < 20 && !(row_vld && row_idx == 1); k++) step();
        chk("t2_reach_row1", row_vld && (row_idx == 1), 1'b1);
        row_rdy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t2_hold_vld", row_vld, 1'b1);
            chk("t2_hold_idx", row_idx, 1);
            chk("t2_no_req", val_vld_o, 1'b0);
        end
        row_rdy = 1'b1;
        run_to_idle("t2_idle", 40);
        ea = '{0, 1, 2, 3};
        check_run("t2", bi, br, bd, ea, ea);

        // abort in WAIT at row 2 with a slow generator
        gen_lat = 2;
        bi = n_iss; br = n_rows; bd = n_done;
        start(1, 3);
        for (k = 0; k < 40 && !(busy && row_idx == 2 && !val_vld_o); k++) step();
        chk("t3_reach_wait2", busy && (row_idx == 2) && !val_vld_o, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        seen = 0;
        for (k = 0; k < 20 && busy; k++) begin
            if (row_vld) seen++;
            step();
        end
        chk("t3_idle", busy, 1'b0);
        chk("t3_row_hidden", seen, 0);
        chk("t3_cfg_rdy", cfg_rdy, 1'b1);
        chk("t3_no_done", n_done - bd, 0);
        chk("t3_rows", n_rows - br, 2);
        chk("t3_reqs", n_iss - bi, 3);
        chk("t3_drained", gen_vld, 1'b0);

        // restart after abort with equal positions
        gen_lat = 0;
        bi = n_iss; br = n_rows; bd = n_done;
        start(2, 2);
        chk("t4_restart_idx", row_idx, 0);
        chk("t4_restart_z0", z0_o, 32'h0002_0000);
        run_to_idle("t4_idle", 40);
        ea = '{2, 3, 0, 1};
        check_run("t4", bi, br, bd, ea, ea);

        // abort in ISSUE before any handshake
        val_rdy = 1'b0;
        bi = n_iss; bd = n_done;
        start(1, 3);
        chk("t5_val_vld", val_vld_o, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_cfg_rdy", cfg_rdy, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_val_vld_off", val_vld_o, 1'b0);
        step();
        chk("t5_no_req", n_iss - bi, 0);
        chk("t5_no_done", n_done - bd, 0);
        val_rdy = 1'b1;

        // async reset while waiting on row 1
        gen_lat = 2;
        start(1, 3);
        for (k = 0; k < 40 && !(busy && row_idx == 1 && !val_vld_o); k++) step();
        chk("t6_reach_wait1", busy && (row_idx == 1) && !val_vld_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_cfg_rdy", cfg_rdy, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_val_vld", val_vld_o, 1'b0);
        chk("t6_gen_rdy", gen_rdy_o, 1'b0);
        chk("t6_row_vld", row_vld, 1'b0);
        chk("t6_row_idx", row_idx, 0);
        chk("t6_row_last", row_last, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_z0", z0_o, 32'h0);
        chk("t6_z1", z1_o, 32'h0);
        chk("t6_s_i", s_val_i_o, 32'h0);
        chk("t6_a1_r", a1_val_r_o, 32'h0);
        step();
        rst = 1'b0;
        gen_lat = 0;
        step();
        bi = n_iss; br = n_rows; bd = n_done;
        start(3, 0);
        run_to_idle("t6_idle", 40);
        ea = '{3, 0, 1, 2};
        eb = '{0, 1, 2, 3};
        check_run("t6", bi, br, bd, ea, eb);

        chk("never_both_high", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
